// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator: maps note-on/note-off commands onto NUM_VOICES voices.
// A command is latched in IDLE, every voice is examined one per cycle in SCAN,
// and the result is applied in COMMIT. all_off releases every voice at once.
// Build option: define MIDI_VOICE_STEAL_EN to steal a voice (round-robin) when
// all voices are busy; otherwise such a note-on is dropped. In both builds the
// overflow output pulses when a note-on finds no free voice.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 16,
  parameter int NOTE_W     = 7,
  parameter int VEL_W      = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_on,
  input  logic [NOTE_W-1:0]            cmd_note,
  input  logic [VEL_W-1:0]             cmd_vel,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
  output logic [4:0]                   active_count,
  output logic                         overflow
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic [IDX_W-1:0]    idx;
  logic                lat_on;
  logic [NOTE_W-1:0]   lat_note;
  logic [VEL_W-1:0]    lat_vel;
  logic                match_found, free_found;
  logic [IDX_W-1:0]    match_idx, free_idx;
  logic [NOTE_W-1:0]   note_q [NUM_VOICES];
  logic [VEL_W-1:0]    vel_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, trig_q;
  logic                ovf_q;
`ifdef MIDI_VOICE_STEAL_EN
  logic [IDX_W-1:0]    steal_ptr;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode; all_off forces IDLE from any state
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = !rst;
        accept    = cmd_valid && !rst && !all_off;
        if (accept) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        if (idx == IDX_W'(NUM_VOICES - 1)) state_nxt = S_COMMIT;
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (all_off) state_nxt = S_IDLE;
  end

  // Command latch, voice scan and commit of the voice table
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      lat_on      <= 1'b0;
      lat_note    <= '0;
      lat_vel     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      gate_q      <= '0;
      trig_q      <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
`ifdef MIDI_VOICE_STEAL_EN
      steal_ptr   <= '0;
`endif
    end else begin
      trig_q <= '0;
      ovf_q  <= 1'b0;
      if (all_off) begin
        gate_q <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              // velocity 0 on a note-on is a note-off
              lat_on      <= cmd_on && (cmd_vel != '0);
              lat_note    <= cmd_note;
              lat_vel     <= cmd_vel;
              idx         <= '0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              match_idx   <= '0;
              free_idx    <= '0;
            end
          end
          S_SCAN: begin
            if (gate_q[idx] && (note_q[idx] == lat_note) && !match_found) begin
              match_found <= 1'b1;
              match_idx   <= idx;
            end
            if (!gate_q[idx] && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
            idx <= idx + 1'b1;
          end
          S_COMMIT: begin
            if (lat_on) begin
              if (match_found) begin
                vel_q[match_idx]  <= lat_vel;
                trig_q[match_idx] <= 1'b1;
              end else if (free_found) begin
                gate_q[free_idx] <= 1'b1;
                note_q[free_idx] <= lat_note;
                vel_q[free_idx]  <= lat_vel;
                trig_q[free_idx] <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
`ifdef MIDI_VOICE_STEAL_EN
                // every gate is set here, so the stolen voice keeps sounding
                note_q[steal_ptr] <= lat_note;
                vel_q[steal_ptr]  <= lat_vel;
                trig_q[steal_ptr] <= 1'b1;
                steal_ptr         <= steal_ptr + 1'b1;
`endif
              end
            end else if (match_found) begin
              gate_q[match_idx] <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pack per-voice note/velocity onto the flat output buses
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
    assign voice_vel[g*VEL_W +: VEL_W]    = vel_q[g];
  end

  assign voice_gate = gate_q;
  assign voice_trig = trig_q;
  assign overflow   = ovf_q;

  // Population count of the gates
  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active_count = active_count + {4'b0, gate_q[i]};
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator (default 16 voices).
// Honors MIDI_VOICE_STEAL_EN for the full-voice expectations.
module tb_midi_voice_allocator;

  localparam int NV = 16;
  localparam int NW = 7;
  localparam int VW = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_on = 1'b0;
  logic [NW-1:0]     cmd_note = '0;
  logic [VW-1:0]     cmd_vel = '0;
  logic              all_off = 1'b0;
  logic [NV-1:0]     voice_gate, voice_trig;
  logic [NV*NW-1:0]  voice_note;
  logic [NV*VW-1:0]  voice_vel;
  logic [4:0]        active_count;
  logic              overflow;

  midi_voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .VEL_W(VW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_on(cmd_on), .cmd_note(cmd_note), .cmd_vel(cmd_vel), .all_off(all_off),
    .voice_gate(voice_gate), .voice_trig(voice_trig), .voice_note(voice_note),
    .voice_vel(voice_vel), .active_count(active_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int             due;
    logic [NV-1:0]  gate;
    logic [NV-1:0]  trig;
    logic           ovf;
    logic [NV*NW-1:0] note;
    logic [NV*VW-1:0] vel;
  } sb_t;

  sb_t sb[$];

  // reference voice table
  logic [NV-1:0]    m_gate = '0;
  logic [NV*NW-1:0] m_note = '0;
  logic [NV*VW-1:0] m_vel  = '0;
  int               m_sp   = 0;

  task automatic model_apply(input logic on, input logic [NW-1:0] n,
                             input logic [VW-1:0] v, output sb_t e);
    int mi, fi;
    mi = -1; fi = -1;
    e.trig = '0; e.ovf = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (m_gate[i] && m_note[i*NW +: NW] == n && mi < 0) mi = i;
      if (!m_gate[i] && fi < 0) fi = i;
    end
    if (on && v != 0) begin
      if (mi >= 0) begin
        m_vel[mi*VW +: VW] = v; e.trig[mi] = 1'b1;
      end else if (fi >= 0) begin
        m_gate[fi] = 1'b1; m_note[fi*NW +: NW] = n; m_vel[fi*VW +: VW] = v; e.trig[fi] = 1'b1;
      end else begin
        e.ovf = 1'b1;
`ifdef MIDI_VOICE_STEAL_EN
        m_note[m_sp*NW +: NW] = n; m_vel[m_sp*VW +: VW] = v; e.trig[m_sp] = 1'b1;
        m_sp = (m_sp + 1) % NV;
`endif
      end
    end else if (mi >= 0) begin
      m_gate[mi] = 1'b0;
    end
    e.gate = m_gate; e.note = m_note; e.vel = m_vel;
  endtask

  // compare the committed result at its due cycle; elsewhere no pulses allowed
  bit mon_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb.size() > 0 && cyc == sb[0].due) begin
        sb_t e;
        e = sb.pop_front();
        chk("gate",  voice_gate, e.gate);
        chk("trig",  voice_trig, e.trig);
        chk("ovf",   overflow, e.ovf);
        chk("note",  voice_note, e.note);
        chk("vel",   voice_vel, e.vel);
        chk("count", active_count, $countones(e.gate));
        chk("ready_after", cmd_ready, 1'b1);
      end else begin
        chk("stray_trig", voice_trig, '0);
        chk("stray_ovf",  overflow, 1'b0);
      end
    end
  end

  task automatic send(input logic on, input logic [NW-1:0] n, input logic [VW-1:0] v, input bit push);
    int b;
    sb_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_on = on; cmd_note = n; cmd_vel = v;
    b = 0;
    while (!cmd_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) chk("ready_timeout", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    if (push) begin
      model_apply(on, n, v, e);
      e.due = cyc + NV + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || !cmd_ready) && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic panic();
    @(negedge clk);
    all_off = 1'b1;
    @(posedge clk);
    #1;
    m_gate = '0;
    chk("panic_gate",  voice_gate, '0);
    chk("panic_trig",  voice_trig, '0);
    chk("panic_count", active_count, 5'd0);
    chk("panic_ready", cmd_ready, 1'b1);
    @(negedge clk);
    all_off = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_gate",  voice_gate, '0);
    chk("rst_count", active_count, 5'd0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_note",  voice_note, '0);
    mon_en = 1'b1;

    // 2: single note-on
    send(1'b1, 7'd60, 7'd100, 1'b1);
    drain();
    chk("t2_note0", voice_note[6:0], 7'd60);
    chk("t2_vel0",  voice_vel[6:0], 7'd100);
    chk("t2_count", active_count, 5'd1);

    // 3: retrigger of held note
    panic();
    send(1'b1, 7'd60, 7'd100, 1'b1);
    send(1'b1, 7'd64, 7'd80,  1'b1);
    send(1'b1, 7'd60, 7'd50,  1'b1);
    drain();
    chk("t3_note1", voice_note[13:7], 7'd64);
    chk("t3_vel0",  voice_vel[6:0], 7'd50);
    chk("t3_count", active_count, 5'd2);

    // 4: release then reuse
    panic();
    send(1'b1, 7'd60, 7'd100, 1'b1);
    send(1'b1, 7'd64, 7'd80,  1'b1);
    send(1'b0, 7'd60, 7'd0,   1'b1);
    send(1'b0, 7'd99, 7'd10,  1'b1);
    send(1'b1, 7'd67, 7'd90,  1'b1);
    drain();
    chk("t4_note0", voice_note[6:0], 7'd67);
    chk("t4_note1", voice_note[13:7], 7'd64);
    chk("t4_gate",  voice_gate, 16'h0003);

    // 5: all voices busy
    panic();
    for (int i = 0; i < NV; i++) send(1'b1, 7'(40 + i), 7'd100, 1'b1);
    send(1'b1, 7'd70, 7'd1, 1'b1);
    send(1'b1, 7'd71, 7'd1, 1'b1);
    drain();
    chk("t5_count", active_count, 5'd16);
`ifdef MIDI_VOICE_STEAL_EN
    chk("t5_steal0", voice_note[6:0], 7'd70);
    chk("t5_steal1", voice_note[13:7], 7'd71);
`else
    chk("t5_keep0", voice_note[6:0], 7'd40);
    chk("t5_keep1", voice_note[13:7], 7'd41);
`endif

    // 6: velocity-0 release, then panic mid-scan
    panic();
    send(1'b1, 7'd60, 7'd100, 1'b1);
    send(1'b1, 7'd60, 7'd0,   1'b1);
    drain();
    chk("t6_gate0", voice_gate[0], 1'b0);
    send(1'b1, 7'd61, 7'd100, 1'b0);
    repeat (5) @(negedge clk);
    panic();
    repeat (25) @(negedge clk);
    chk("t6_no61_gate", voice_gate, '0);
    chk("t6_ready", cmd_ready, 1'b1);
    send(1'b1, 7'd62, 7'd30, 1'b1);
    drain();
    chk("t6_after", voice_note[6:0], 7'd62);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
